lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 144 ++++++++++++++
 tb/tb_lfsr_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to a Galois LFSR word stream, then flywheels and counts mismatches.
// Optional error counter enabled by defining LFSR_CHK_ERRCNT_EN; otherwise err_count is tied to 0 and clear is ignored.
module lfsr_checker #(
  parameter int              LEN      = 8,
  parameter logic [LEN-1:0]  TAPS     = 8'b10111000,
  parameter int              LOCK_CNT = 4,
  parameter int              LOSS_CNT = 3,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [LEN-1:0]   in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [LEN-1:0]   expected
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

  function automatic logic [LEN-1:0] step(input logic [LEN-1:0] s);
    return {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : '0);
  endfunction

  state_t         state_q, state_d;
  logic [LEN-1:0] pred_q, pred_d;
  logic [7:0]     match_q, match_d;
  logic [7:0]     miss_q, miss_d;
  logic           locked_q, locked_d;
  logic           pulse_q, pulse_d;
  logic           err_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // The all-zero word is the LFSR lockup value and cannot seed a sequence.
          if (in_data != '0) begin
            pred_d  = step(in_data);
            match_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (in_data == pred_q) begin
            pred_d  = step(in_data);
            match_d = match_q + 8'd1;
            if (match_d == LOCK_C) begin
              state_d  = LOCK;
              locked_d = 1'b1;
            end
          end else if (in_data != '0) begin
            pred_d  = step(in_data);
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          // Flywheel: once locked, the prediction never reseeds from received data.
          pred_d = step(pred_q);
          if (in_data == pred_q) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_q + 8'd1;
            if (miss_d == LOSS_C) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              pred_d   = '0;
              miss_d   = '0;
              match_d  = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // clear has priority over a same-cycle increment; the count saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = clear ^ err_inc;
  assign err_count = '0;
`endif

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign expected  = pred_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed test-plan steps plus a randomized phase, checked against a behavioural model.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;

  int checks = 0;
  int failures = 0;

  // Behavioural reference state
  bit m_locked, m_synced, m_pulse;
  int m_run, m_miss, m_pred, m_errs;

  lfsr_checker dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  function automatic int nxt(input int s);
    return (s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
  endfunction

  task automatic model(input bit r, input bit v, input int d, input bit c);
    bit inc = 0;
    if (!r) begin
      m_locked = 0; m_synced = 0; m_pulse = 0;
      m_run = 0; m_miss = 0; m_pred = 0; m_errs = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (m_locked) begin
        int want = m_pred;
        m_pred = nxt(m_pred);
        if (d == want) m_miss = 0;
        else begin
          m_pulse = 1; inc = 1; m_miss++;
          if (m_miss == 3) begin
            m_locked = 0; m_synced = 0; m_pred = 0; m_miss = 0; m_run = 0;
          end
        end
      end else if (m_synced) begin
        if (d == m_pred) begin
          m_pred = nxt(d); m_run++;
          if (m_run == 4) m_locked = 1;
        end else if (d != 0) begin
          m_pred = nxt(d); m_run = 0;
        end else m_synced = 0;
      end else if (d != 0) begin
        m_synced = 1; m_pred = nxt(d); m_run = 0;
      end
    end
`ifdef LFSR_CHK_ERRCNT_EN
    if (c) m_errs = 0;
    else if (inc && m_errs < 65535) m_errs++;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit c);
    rst_n = r; in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    model(r, v, int'(d), c);
    #1;
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_errs));
    chk("expected", 32'(expected), 32'(m_pred));
  endtask

  initial begin
    logic [7:0] acq [5];
    int cnt_one;
    acq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
`ifdef LFSR_CHK_ERRCNT_EN
    cnt_one = 1;
`else
    cnt_one = 0;
`endif

    // Reset
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_expected", 32'(expected), 0);
    chk("rst_count", 32'(err_count), 0);

    // Acquisition
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, acq[i], 0);
      if (i == 0) chk("acq_exp1", 32'(expected), 32'h B8);
      if (i < 4) chk("acq_unlocked", 32'(locked), 0);
    end
    chk("acq_locked", 32'(locked), 1);
    chk("acq_exp5", 32'(expected), 32'h B3);

    // Single error then recovery
    cyc(1, 1, 8'hFF, 0);
    chk("se_pulse", 32'(err_pulse), 1);
    chk("se_count", 32'(err_count), 32'(cnt_one));
    chk("se_exp", 32'(expected), 32'h E1);
    cyc(1, 1, 8'hE1, 0);
    chk("se_nopulse", 32'(err_pulse), 0);
    chk("se_locked", 32'(locked), 1);
    cyc(1, 0, 8'h00, 1);

    // Loss of lock
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 8'(m_pred ^ 'h40), 0);
      chk("loss_pulse", 32'(err_pulse), 1);
    end
    chk("loss_locked", 32'(locked), 0);
    chk("loss_count", 32'(err_count), 32'(3 * cnt_one));

    // All-zero stream
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'h00, 0);
    chk("zero_locked", 32'(locked), 0);
    chk("zero_exp", 32'(expected), 0);

    // Acquisition with gaps
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, acq[i], 0);
      repeat ($urandom_range(3, 1)) cyc(1, 0, 8'($urandom), 0);
    end
    chk("gap_locked", 32'(locked), 1);
    chk("gap_exp", 32'(expected), 32'h B3);

    // Clear coincident with a mismatch
    cyc(1, 1, 8'h00, 1);
    chk("clr_pulse", 32'(err_pulse), 1);
    chk("clr_count", 32'(err_count), 0);
    chk("clr_locked", 32'(locked), 1);

    // Reset while locked with a non-zero count
    cyc(1, 1, 8'(m_pred), 0);
    cyc(1, 1, 8'(m_pred ^ 'h01), 0);
    chk("pre_rst_count", 32'(err_count), 32'(cnt_one));
    cyc(0, 0, 8'h00, 0);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_count", 32'(err_count), 0);

    // Randomized phase: true sequence with sparse corruption, gaps and clears
    begin
      int s;
      s = $urandom_range(255, 1);
      for (int i = 0; i < 400; i++) begin
        bit v, c;
        logic [7:0] d;
        v = ($urandom_range(3, 0) != 0);
        c = ($urandom_range(15, 0) == 0);
        d = 8'(s);
        if ($urandom_range(9, 0) == 0) d = 8'($urandom);
        if ((i % 100) == 99) s = $urandom_range(255, 1);
        cyc(1, v, d, c);
        if (v) s = nxt(s);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
